// File: rtl/fp_align_if.sv
// Handshake bundles around the alignment stage: the operand bundle coming in
// from extraction, and the aligned bundle going out to add/normalise.

interface fp_align_in_if #(
    parameter int FRAC_W = 53,
    parameter int EXP_W  = 16
);
    logic              i_valid;
    logic              o_ready;
    logic              i_mode;
    logic [EXP_W-1:0]  e_large_exp;
    logic [EXP_W-1:0]  e_small_exp;
    logic [FRAC_W-1:0] e_large_frac53;
    logic [FRAC_W-1:0] e_small_frac53;
    logic [1:0]        e_large_hidden_bit;
    logic [1:0]        e_small_hidden_bit;
    logic [1:0]        e_large_expff;
    logic [1:0]        e_small_expff;
    logic [1:0]        e_large_frac00;
    logic [1:0]        e_small_frac00;
    logic [1:0]        e_op;
    logic [1:0]        e_Ls;

    // Producer side (extraction stage or a bench driver)
    modport master (
        output i_valid, i_mode, e_large_exp, e_small_exp,
               e_large_frac53, e_small_frac53,
               e_large_hidden_bit, e_small_hidden_bit,
               e_large_expff, e_small_expff,
               e_large_frac00, e_small_frac00, e_op, e_Ls,
        input  o_ready
    );

    // Consumer side (the alignment stage)
    modport slave (
        input  i_valid, i_mode, e_large_exp, e_small_exp,
               e_large_frac53, e_small_frac53,
               e_large_hidden_bit, e_small_hidden_bit,
               e_large_expff, e_small_expff,
               e_large_frac00, e_small_frac00, e_op, e_Ls,
        output o_ready
    );
endinterface

interface fp_align_out_if #(
    parameter int FRAC_W = 53,
    parameter int EXP_W  = 16
);
    logic              a_valid;
    logic              a_ready;
    logic              a_mode;
    logic [EXP_W-1:0]  a_exp;
    logic [FRAC_W-1:0] a_large_frac;
    logic [FRAC_W-1:0] a_small_frac;
    logic [5:0]        a_grs;
    logic [1:0]        a_op;
    logic [1:0]        a_Ls;
    logic [1:0]        a_nan;
    logic [1:0]        a_inf;
    logic [1:0]        a_invalid;

    // Producer side (the alignment stage)
    modport master (
        output a_valid, a_mode, a_exp, a_large_frac, a_small_frac, a_grs,
               a_op, a_Ls, a_nan, a_inf, a_invalid,
        input  a_ready
    );

    // Consumer side (add/normalise stage or a bench monitor)
    modport slave (
        input  a_valid, a_mode, a_exp, a_large_frac, a_small_frac, a_grs,
               a_op, a_Ls, a_nan, a_inf, a_invalid,
        output a_ready
    );
endinterface

// File: rtl/fp_align.sv
// Two-stage alignment for the dual-mode FP adder. S1 captures the bundle and
// the per-lane exponent differences; S2 holds the aligned small significand
// with guard/round/sticky and the NaN/Inf/invalid classification.

module fp_align #(
    parameter int FRAC_W = 53,
    parameter int EXP_W  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fp_align_in_if.slave   up,
    fp_align_out_if.master dn
);
    localparam int DEXT   = FRAC_W + 2;   // double field plus guard/round slots
    localparam int SW     = 24;           // single-lane significand width
    localparam int SEXT   = SW + 2;
    localparam int L1_LSB = 29;           // lane1 field starts here

    logic s1_load;
    logic s2_load;
    logic s1_v_reg;
    logic s2_v_reg;

    // ---------------- S1 combinational: effective exponent differences
    logic [10:0]      eff_large_d;
    logic [10:0]      eff_small_d;
    logic [10:0]      d_dbl;
    logic [1:0][7:0]  d_lane;

    // A cleared hidden bit marks a denormal, whose effective exponent is 1
    assign eff_large_d = up.e_large_hidden_bit[0] ? up.e_large_exp[10:0] : 11'd1;
    assign eff_small_d = up.e_small_hidden_bit[0] ? up.e_small_exp[10:0] : 11'd1;
    assign d_dbl       = eff_large_d - eff_small_d;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_s1_lane
            logic [7:0] eff_l;
            logic [7:0] eff_s;
            assign eff_l      = up.e_large_hidden_bit[gi] ? up.e_large_exp[8*gi +: 8] : 8'd1;
            assign eff_s      = up.e_small_hidden_bit[gi] ? up.e_small_exp[8*gi +: 8] : 8'd1;
            assign d_lane[gi] = eff_l - eff_s;
        end
    endgenerate

    // ---------------- S1 registers
    logic              s1_mode_reg;
    logic [EXP_W-1:0]  s1_exp_reg;
    logic [FRAC_W-1:0] s1_lfrac_reg;
    logic [FRAC_W-1:0] s1_sfrac_reg;
    logic [10:0]       s1_dd_reg;
    logic [1:0][7:0]   s1_dl_reg;
    logic [1:0]        s1_lff_reg;
    logic [1:0]        s1_sff_reg;
    logic [1:0]        s1_lz_reg;
    logic [1:0]        s1_sz_reg;
    logic [1:0]        s1_op_reg;
    logic [1:0]        s1_ls_reg;

    // S2 may take S1's bundle when it is empty or its own bundle is leaving;
    // S1 may accept whenever it is empty or will drain this cycle.
    assign s2_load    = s1_v_reg & (~s2_v_reg | dn.a_ready);
    assign up.o_ready = ~s1_v_reg | ~s2_v_reg | dn.a_ready;
    assign s1_load    = up.i_valid & up.o_ready;

    // Stage 1: capture the incoming bundle and its exponent differences
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v_reg     <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_lfrac_reg <= '0;
            s1_sfrac_reg <= '0;
            s1_dd_reg    <= '0;
            s1_dl_reg    <= '0;
            s1_lff_reg   <= '0;
            s1_sff_reg   <= '0;
            s1_lz_reg    <= '0;
            s1_sz_reg    <= '0;
            s1_op_reg    <= '0;
            s1_ls_reg    <= '0;
        end else begin
            s1_v_reg <= s1_load | (s1_v_reg & ~s2_load);
            if (s1_load) begin
                s1_mode_reg  <= up.i_mode;
                s1_exp_reg   <= up.e_large_exp;
                s1_lfrac_reg <= up.e_large_frac53;
                s1_sfrac_reg <= up.e_small_frac53;
                s1_dd_reg    <= d_dbl;
                s1_dl_reg    <= d_lane;
                s1_lff_reg   <= up.e_large_expff;
                s1_sff_reg   <= up.e_small_expff;
                s1_lz_reg    <= up.e_large_frac00;
                s1_sz_reg    <= up.e_small_frac00;
                s1_op_reg    <= up.e_op;
                s1_ls_reg    <= up.e_Ls;
            end
        end
    end

    // ---------------- S2 combinational: double-precision shift
    logic [DEXT-1:0] ext_dbl;
    logic [DEXT-1:0] shifted_dbl;
    logic [DEXT-1:0] mask_dbl;
    logic [5:0]      sh_dbl;
    logic            sticky_dbl;

    // Saturating the distance at the full extended width empties the field,
    // so guard and round fall to zero and every bit lands in sticky.
    assign ext_dbl     = {s1_sfrac_reg, 2'b00};
    assign sh_dbl      = (s1_dd_reg > 11'd55) ? 6'd55 : s1_dd_reg[5:0];
    assign shifted_dbl = ext_dbl >> sh_dbl;
    assign mask_dbl    = ~({DEXT{1'b1}} << sh_dbl);
    assign sticky_dbl  = |(ext_dbl & mask_dbl);

    // ---------------- S2 combinational: single lanes and special flags
    logic [1:0][SW-1:0] lane_frac;
    logic [1:0][2:0]    lane_grs;
    logic [1:0]         lane_nan;
    logic [1:0]         lane_inf;
    logic [1:0]         lane_inv;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_s2_lane
            logic [SEXT-1:0] ext;
            logic [SEXT-1:0] shifted;
            logic [SEXT-1:0] mask;
            logic [4:0]      sh;
            logic            l_nan;
            logic            s_nan;
            logic            l_inf;
            logic            s_inf;
            logic            inv;

            // Each lane shifts inside its own field so nothing crosses lanes
            assign ext     = {s1_sfrac_reg[L1_LSB*gi +: SW], 2'b00};
            assign sh      = (s1_dl_reg[gi] > 8'd26) ? 5'd26 : s1_dl_reg[gi][4:0];
            assign shifted = ext >> sh;
            assign mask    = ~({SEXT{1'b1}} << sh);

            assign lane_frac[gi] = shifted[SEXT-1:2];
            assign lane_grs[gi]  = {shifted[1:0], |(ext & mask)};

            assign l_nan = s1_lff_reg[gi] & ~s1_lz_reg[gi];
            assign s_nan = s1_sff_reg[gi] & ~s1_sz_reg[gi];
            assign l_inf = s1_lff_reg[gi] &  s1_lz_reg[gi];
            assign s_inf = s1_sff_reg[gi] &  s1_sz_reg[gi];
            assign inv   = s1_op_reg[gi] & l_inf & s_inf;

            // Inf - Inf is reported as a NaN, never as an infinity
            assign lane_inv[gi] = inv;
            assign lane_nan[gi] = l_nan | s_nan | inv;
            assign lane_inf[gi] = ~(l_nan | s_nan) & (l_inf | s_inf) & ~inv;
        end
    endgenerate

    logic [FRAC_W-1:0] small_frac_next;
    logic [5:0]        grs_next;
    logic [1:0]        nan_next;
    logic [1:0]        inf_next;
    logic [1:0]        inv_next;

    // Double mode mirrors lane0 flags into bit1 and leaves lane1 grs empty
    assign small_frac_next = s1_mode_reg ? shifted_dbl[DEXT-1:2]
                                         : {lane_frac[1], 5'b00000, lane_frac[0]};
    assign grs_next = s1_mode_reg ? {3'b000, shifted_dbl[1:0], sticky_dbl}
                                  : {lane_grs[1], lane_grs[0]};
    assign nan_next = s1_mode_reg ? {2{lane_nan[0]}} : lane_nan;
    assign inf_next = s1_mode_reg ? {2{lane_inf[0]}} : lane_inf;
    assign inv_next = s1_mode_reg ? {2{lane_inv[0]}} : lane_inv;

    // ---------------- S2 registers (drive the outputs directly)
    logic              s2_mode_reg;
    logic [EXP_W-1:0]  s2_exp_reg;
    logic [FRAC_W-1:0] s2_lfrac_reg;
    logic [FRAC_W-1:0] s2_sfrac_reg;
    logic [5:0]        s2_grs_reg;
    logic [1:0]        s2_op_reg;
    logic [1:0]        s2_ls_reg;
    logic [1:0]        s2_nan_reg;
    logic [1:0]        s2_inf_reg;
    logic [1:0]        s2_inv_reg;

    // Stage 2: hold the aligned bundle until downstream takes it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_v_reg     <= 1'b0;
            s2_mode_reg  <= 1'b0;
            s2_exp_reg   <= '0;
            s2_lfrac_reg <= '0;
            s2_sfrac_reg <= '0;
            s2_grs_reg   <= '0;
            s2_op_reg    <= '0;
            s2_ls_reg    <= '0;
            s2_nan_reg   <= '0;
            s2_inf_reg   <= '0;
            s2_inv_reg   <= '0;
        end else begin
            s2_v_reg <= s2_load | (s2_v_reg & ~dn.a_ready);
            if (s2_load) begin
                s2_mode_reg  <= s1_mode_reg;
                s2_exp_reg   <= s1_exp_reg;
                s2_lfrac_reg <= s1_lfrac_reg;
                s2_sfrac_reg <= small_frac_next;
                s2_grs_reg   <= grs_next;
                s2_op_reg    <= s1_op_reg;
                s2_ls_reg    <= s1_ls_reg;
                s2_nan_reg   <= nan_next;
                s2_inf_reg   <= inf_next;
                s2_inv_reg   <= inv_next;
            end
        end
    end

    assign dn.a_valid      = s2_v_reg;
    assign dn.a_mode       = s2_mode_reg;
    assign dn.a_exp        = s2_exp_reg;
    assign dn.a_large_frac = s2_lfrac_reg;
    assign dn.a_small_frac = s2_sfrac_reg;
    assign dn.a_grs        = s2_grs_reg;
    assign dn.a_op         = s2_op_reg;
    assign dn.a_Ls         = s2_ls_reg;
    assign dn.a_nan        = s2_nan_reg;
    assign dn.a_inf        = s2_inf_reg;
    assign dn.a_invalid    = s2_inv_reg;
endmodule

// File: tb/tb_fp_align.sv
// Bench for fp_align: directed and random bundles, expectations from an
// arithmetic reference model pushed to a scoreboard, popped by a monitor.

module tb_fp_align;
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    fp_align_in_if  up ();
    fp_align_out_if dn ();

    fp_align dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .up    (up),
        .dn    (dn)
    );

    typedef struct packed {
        logic        mode;
        logic [15:0] lexp, sexp;
        logic [52:0] lfrac, sfrac;
        logic [1:0]  lhid, shid, lff, sff, lz, sz, op, ls;
    } in_t;

    typedef struct packed {
        logic        mode;
        logic [15:0] exp;
        logic [52:0] lfrac, sfrac;
        logic [5:0]  grs;
        logic [1:0]  op, ls, nan, inf, inv;
    } out_t;

    out_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_ready = 0;
    bit   bp_done;

    task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic out_t get_out();
        out_t o;
        o.mode = dn.a_mode;   o.exp = dn.a_exp;
        o.lfrac = dn.a_large_frac; o.sfrac = dn.a_small_frac;
        o.grs = dn.a_grs;     o.op = dn.a_op;   o.ls = dn.a_Ls;
        o.nan = dn.a_nan;     o.inf = dn.a_inf; o.inv = dn.a_invalid;
        return o;
    endfunction

    // ---------------- reference model
    // Shift by plain arithmetic: what stays is the quotient, what is lost is
    // the remainder; guard/round are the two lowest kept bits.
    function automatic void align(input logic [52:0] field, input int d, input int w,
                                  output logic [52:0] kept, output logic [2:0] grs);
        logic [63:0] ext, q, lost;
        ext = 64'(field) * 64'd4;
        if (d >= w + 2) begin
            kept = '0;
            grs  = {2'b00, field != 0};
        end else begin
            q    = ext >> d;
            lost = ext - (q << d);
            kept = 53'(q >> 2);
            grs  = {q[1], q[0], lost != 0};
        end
    endfunction

    // Returns {nan, inf, invalid} for one lane
    function automatic logic [2:0] special(input logic lff, input logic lz,
                                           input logic sff, input logic sz, input logic op);
        bit any_nan, any_inf, both_inf, invalid;
        any_nan  = (lff && !lz) || (sff && !sz);
        both_inf = (lff && lz) && (sff && sz);
        any_inf  = (lff && lz) || (sff && sz);
        invalid  = op && both_inf;
        if (invalid)      return 3'b101;
        else if (any_nan) return 3'b100;
        else if (any_inf) return 3'b010;
        else              return 3'b000;
    endfunction

    function automatic out_t passthru(input in_t b);
        out_t e = '0;
        e.mode = b.mode; e.exp = b.lexp; e.lfrac = b.lfrac; e.op = b.op; e.ls = b.ls;
        return e;
    endfunction

    function automatic out_t model(input in_t b);
        out_t e = passthru(b);
        logic [52:0] k;
        logic [2:0]  g, s;
        int el, es;
        if (b.mode) begin
            el = b.lhid[0] ? int'(b.lexp[10:0]) : 1;
            es = b.shid[0] ? int'(b.sexp[10:0]) : 1;
            align(b.sfrac, el - es, 53, k, g);
            e.sfrac = k;
            e.grs   = {3'b000, g};
            s = special(b.lff[0], b.lz[0], b.sff[0], b.sz[0], b.op[0]);
            e.nan = {2{s[2]}}; e.inf = {2{s[1]}}; e.inv = {2{s[0]}};
        end else begin
            for (int ln = 0; ln < 2; ln++) begin
                el = b.lhid[ln] ? int'(b.lexp[8*ln +: 8]) : 1;
                es = b.shid[ln] ? int'(b.sexp[8*ln +: 8]) : 1;
                align(53'(b.sfrac[29*ln +: 24]), el - es, 24, k, g);
                e.sfrac[29*ln +: 24] = k[23:0];
                e.grs[3*ln +: 3] = g;
                s = special(b.lff[ln], b.lz[ln], b.sff[ln], b.sz[ln], b.op[ln]);
                e.nan[ln] = s[2]; e.inf[ln] = s[1]; e.inv[ln] = s[0];
            end
        end
        return e;
    endfunction

    // ---------------- random bundle generator (large >= small per lane)
    function automatic in_t rand_bundle();
        in_t b;
        logic [63:0] r;
        r = {$urandom, $urandom}; b.lfrac = r[52:0];
        r = {$urandom, $urandom}; b.sfrac = r[52:0];
        if ($urandom_range(0, 3) == 0) b.sfrac[15:0] = '0;
        b.mode = 1'($urandom_range(0, 1));
        b.op = 2'($urandom); b.ls = 2'($urandom);
        b.lz = 2'($urandom); b.sz = 2'($urandom);
        b.lexp = 16'($urandom); b.sexp = 16'($urandom);
        b.lhid = 2'($urandom); b.shid = 2'($urandom);
        b.lff = 2'($urandom); b.sff = 2'($urandom);
        if (b.mode) begin
            int el, es, d;
            el = $urandom_range(1, 2046);
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 3);
                1: d = $urandom_range(0, 60);
                2: d = $urandom_range(50, 58);
                default: d = $urandom_range(0, 2000);
            endcase
            es = (el >= d) ? el - d : 0;
            if ($urandom_range(0, 15) == 0) begin el = 0; es = 0; end
            if ($urandom_range(0, 7) == 0) begin el = 2047; es = 2047; end
            b.lexp[10:0] = 11'(el); b.sexp[10:0] = 11'(es);
            b.lhid[0] = (el != 0); b.shid[0] = (es != 0);
            b.lff[0] = (el == 2047); b.sff[0] = (es == 2047);
        end else begin
            for (int ln = 0; ln < 2; ln++) begin
                int el, es, d;
                el = $urandom_range(1, 254);
                case ($urandom_range(0, 3))
                    0: d = $urandom_range(0, 3);
                    1: d = $urandom_range(0, 30);
                    2: d = $urandom_range(22, 28);
                    default: d = $urandom_range(0, 255);
                endcase
                es = (el >= d) ? el - d : 0;
                if ($urandom_range(0, 15) == 0) begin el = 0; es = 0; end
                if ($urandom_range(0, 7) == 0) begin el = 255; es = 255; end
                b.lexp[8*ln +: 8] = 8'(el); b.sexp[8*ln +: 8] = 8'(es);
                b.lhid[ln] = (el != 0); b.shid[ln] = (es != 0);
                b.lff[ln] = (el == 255); b.sff[ln] = (es == 255);
            end
        end
        return b;
    endfunction

    // ---------------- drivers
    task automatic apply(input in_t b);
        up.i_mode = b.mode;
        up.e_large_exp = b.lexp;          up.e_small_exp = b.sexp;
        up.e_large_frac53 = b.lfrac;      up.e_small_frac53 = b.sfrac;
        up.e_large_hidden_bit = b.lhid;   up.e_small_hidden_bit = b.shid;
        up.e_large_expff = b.lff;         up.e_small_expff = b.sff;
        up.e_large_frac00 = b.lz;         up.e_small_frac00 = b.sz;
        up.e_op = b.op;                   up.e_Ls = b.ls;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input in_t b, input out_t e);
        int w = 0;
        apply(b);
        up.i_valid = 1'b1;
        while (!up.o_ready && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: o_ready stayed %b for %0d cycles, required 1", up.o_ready, w);
            up.i_valid = 1'b0;
            return;
        end
        @(posedge i_clk);
        sb.push_back(e);
        @(negedge i_clk);
        up.i_valid = 1'b0;
    endtask

    // Send with an empty pipe and a_ready = 1, checking the 2-cycle latency
    task automatic send_lat(input string name, input in_t b, input out_t e);
        apply(b);
        up.i_valid = 1'b1;
        check1({name, "_o_ready"}, up.o_ready, 1);
        @(posedge i_clk);
        sb.push_back(e);
        #1;
        check1({name, "_valid_c1"}, dn.a_valid, 0);
        up.i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        check1({name, "_valid_c2"}, dn.a_valid, 1);
        @(negedge i_clk);
    endtask

    task automatic set_ready(input bit v);
        @(posedge i_clk);
        #2;
        dn.a_ready = v;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge i_clk);
            w++;
        end
        check1({name, "_drain_left"}, sb.size(), 0);
    endtask

    // Random ready toggling, moved just after the rising edge
    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            if (rand_ready) dn.a_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard
    initial begin
        out_t cur, e, held;
        bit   hold_v = 0;
        int   txn = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                hold_v = 0;
            end else begin
                cur = get_out();
                if (hold_v) begin
                    n_cmp++;
                    if (cur !== held || dn.a_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL hold: got sf=%h grs=%b valid=%b, held sf=%h grs=%b", cur.sfrac, cur.grs, dn.a_valid, held.sfrac, held.grs);
                    end
                end
                if (dn.a_valid && dn.a_ready) begin
                    hold_v = 0;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_output: got sf=%h with empty scoreboard, required no output", cur.sfrac);
                    end else begin
                        e = sb.pop_front();
                        txn++;
                        if (cur !== e) begin
                            n_err++;
                            $display("FAIL bundle %0d: got mode=%0d exp=%h lf=%h sf=%h grs=%b op=%b ls=%b nan=%b inf=%b inv=%b; want mode=%0d exp=%h lf=%h sf=%h grs=%b op=%b ls=%b nan=%b inf=%b inv=%b",
                                     txn, cur.mode, cur.exp, cur.lfrac, cur.sfrac, cur.grs, cur.op, cur.ls, cur.nan, cur.inf, cur.inv,
                                     e.mode, e.exp, e.lfrac, e.sfrac, e.grs, e.op, e.ls, e.nan, e.inf, e.inv);
                        end else begin
                            $display("txn %0d ok mode=%0d sf=%h grs=%b nan=%b inf=%b inv=%b", txn, cur.mode, cur.sfrac, cur.grs, cur.nan, cur.inf, cur.inv);
                        end
                    end
                end else if (dn.a_valid) begin
                    hold_v = 1;
                    held   = cur;
                end else begin
                    hold_v = 0;
                end
            end
        end
    end

    // ---------------- main sequence
    initial begin
        in_t  b;
        out_t e;

        i_rst = 1'b1;
        dn.a_ready = 1'b0;
        up.i_valid = 1'b0;
        apply('0);
        #1;
        check1("rst_valid", dn.a_valid, 0);
        check1("rst_o_ready", up.o_ready, 1);
        check1("rst_outs_zero", (get_out() == '0), 1);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        set_ready(1);
        @(negedge i_clk);

        // Double 1.0 + 0.5
        b = '0; b.mode = 1; b.lexp = 16'h03FF; b.sexp = 16'h03FE;
        b.lhid = 2'b01; b.shid = 2'b01;
        b.lfrac = 53'h10000000000000; b.sfrac = 53'h10000000000000;
        e = passthru(b); e.sfrac = 53'h08000000000000; e.grs = 6'b000000;
        send_lat("t1", b, e);

        // Double, d = 60 and d = 54
        b.lexp = 16'h043C; b.sexp = 16'h0400; b.sfrac = 53'h1FFFFFFFFFFFFF;
        e = passthru(b); e.sfrac = '0; e.grs = 6'b000001;
        send(b, e);
        b.sexp = 16'h0406;
        e = passthru(b); e.sfrac = '0; e.grs = 6'b000011;
        send(b, e);

        // Single lanes: lane0 d = 2, lane1 d = 25 with all-ones field
        b = '0; b.mode = 0; b.lexp = {8'h9A, 8'h80}; b.sexp = {8'h81, 8'h7E};
        b.lhid = 2'b11; b.shid = 2'b11; b.lfrac = 53'h0ABCDEF;
        b.sfrac = {24'hFFFFFF, 5'h1F, 24'hC00000};
        e = passthru(b); e.sfrac = {24'h000000, 5'h00, 24'h300000}; e.grs = 6'b011000;
        send(b, e);

        // Inf - Inf in double
        b = '0; b.mode = 1; b.lexp = 16'h07FF; b.sexp = 16'h07FF;
        b.lhid = 2'b01; b.shid = 2'b01; b.lff = 2'b01; b.sff = 2'b01;
        b.lz = 2'b01; b.sz = 2'b01; b.op = 2'b01;
        b.lfrac = 53'h10000000000000; b.sfrac = 53'h10000000000000;
        e = passthru(b); e.sfrac = 53'h10000000000000; e.nan = 2'b11; e.inv = 2'b11;
        send(b, e);

        // Lane0 NaN only in single mode
        b = '0; b.mode = 0; b.lexp = {8'h90, 8'hFF}; b.sexp = {8'h90, 8'hFF};
        b.lhid = 2'b11; b.shid = 2'b11; b.lff = 2'b01; b.op = 2'b10;
        b.lfrac = {24'h800000, 5'h00, 24'hC00001};
        b.sfrac = {24'h800000, 5'h00, 24'h800000};
        e = passthru(b); e.sfrac = {24'h800000, 5'h00, 24'h800000}; e.nan = 2'b01;
        send(b, e);
        drain("directed");

        // Random traffic with random backpressure
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            b = rand_bundle();
            send(b, model(b));
        end
        rand_ready = 0;
        set_ready(1);
        drain("random");

        // Backpressure: two accepts fill the pipe, then o_ready stays low
        set_ready(0);
        @(negedge i_clk);
        b = rand_bundle(); send(b, model(b));
        b = rand_bundle(); send(b, model(b));
        check1("bp_o_ready_full", up.o_ready, 0);
        bp_done = 0;
        fork
            begin
                in_t bb;
                bb = rand_bundle(); send(bb, model(bb));
                bb = rand_bundle(); send(bb, model(bb));
                bp_done = 1;
            end
        join_none
        repeat (3) begin
            @(negedge i_clk);
            check1("bp_o_ready_stall", up.o_ready, 0);
            check1("bp_valid_stall", dn.a_valid, 1);
        end
        set_ready(1);
        for (int w = 0; w < 200 && !bp_done; w++) @(negedge i_clk);
        check1("bp_sender_done", bp_done, 1);
        drain("bp");

        // Reset with both stages full
        set_ready(0);
        @(negedge i_clk);
        b = rand_bundle(); send(b, model(b));
        b = rand_bundle(); send(b, model(b));
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check1("rst2_valid", dn.a_valid, 0);
        check1("rst2_o_ready", up.o_ready, 1);
        check1("rst2_outs_zero", (get_out() == '0), 1);
        sb.delete();
        dn.a_ready = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        b = rand_bundle();
        send_lat("post_rst", b, model(b));
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
